// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a busy-bit scoreboard.
// There are two prioritised write ports: ALU writeback (A) and load writeback (B).
// Reads are combinational. They can bypass this cycle's write data.
// An optional hardwired-zero register 0 is supported.
// Busy bits let the decode stage detect RAW hazards.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    // Register storage and scoreboard state.
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Per-register one-hot decode of the write and reserve requests.
    logic [NUM_REGS-1:0] wa_hit;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] rsv_hit;
    logic [NUM_REGS-1:0] wr_any;

    // Temporaries for the read-port loop.
    logic [ADDR_W-1:0]   rp_addr;
    logic [DATA_W-1:0]   rp_word;
    logic                rp_hit_a;
    logic                rp_hit_b;
    logic                rp_pend;

    // Decode the write and reserve addresses into per-register strobes.
    // Register 0 is excluded from every strobe when it is hardwired to zero.
    // Port B is masked wherever port A hits the same register, so A wins a collision.
    always_comb begin
        // NOTE: every always_comb output gets a default first.
        // Without a default, a path that skips an assignment infers a latch.
        wa_hit  = '0;
        wb_hit  = '0;
        rsv_hit = '0;
        wr_any  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!(ZERO_R0 != 0 && r == 0)) begin
                wa_hit[r]  = wa_en  && (wa_addr  == ADDR_W'(r));
                wb_hit[r]  = wb_en  && (wb_addr  == ADDR_W'(r)) && !wa_hit[r];
                rsv_hit[r] = rsv_en && (rsv_addr == ADDR_W'(r));
                // An enabled write to a register retires its producer.
                // This holds even when port A overrides port B's data.
                wr_any[r]  = (wa_en && (wa_addr == ADDR_W'(r))) ||
                             (wb_en && (wb_addr == ADDR_W'(r)));
            end
        end
    end

    // Register array: port A has priority over port B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because registers must read 0 after reset.
            // This keeps it in flops rather than RAM.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // Every flop then samples pre-edge values.
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wa_hit[r]) begin
                    regs[r] <= wa_data;
                end else if (wb_hit[r]) begin
                    regs[r] <= wb_data;
                end
            end
        end
    end

    // Scoreboard: a reserve sets the bit and any enabled write clears it.
    // Set wins when both happen in one cycle, because a new producer issued as the old one retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= rsv_hit | (busy & ~wr_any);
        end
    end

    assign busy_vec = busy;

    // Read ports: bypass this cycle's write data (A first, then B), then force r0 to zero.
    // The hazard flag is dropped when the pending value is being bypassed this cycle.
    // Outputs are held at zero while reset is asserted.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        rp_addr  = '0;
        rp_word  = '0;
        rp_hit_a = 1'b0;
        rp_hit_b = 1'b0;
        rp_pend  = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            rp_addr  = rd_addr[p*ADDR_W +: ADDR_W];
            rp_hit_a = wa_en && (wa_addr == rp_addr);
            rp_hit_b = wb_en && (wb_addr == rp_addr);
            rp_word  = regs[rp_addr];
            if (BYPASS != 0) begin
                if (rp_hit_a) begin
                    rp_word = wa_data;
                end else if (rp_hit_b) begin
                    rp_word = wb_data;
                end
            end
            if (ZERO_R0 != 0 && rp_addr == '0) begin
                rp_word = '0;
            end
            rp_pend = busy[rp_addr] && !((BYPASS != 0) && (rp_hit_a || rp_hit_b));
            if (rst_n) begin
                rd_data[p*DATA_W +: DATA_W] = rp_word;
                rd_busy[p]                  = rp_pend;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. It drives two instances from the same write and reserve stimulus.
// dut_a: BYPASS=1, ZERO_R0=0, NUM_RD=3.
// dut_b: BYPASS=0, ZERO_R0=1, NUM_RD=2.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wa_en, wb_en, rsv_en;
    logic [2:0]  wa_addr, wb_addr, rsv_addr;
    logic [15:0] wa_data, wb_data;
    logic [8:0]  ra_a;
    logic [5:0]  ra_b;
    logic [47:0] rd_data_a;
    logic [2:0]  rd_busy_a;
    logic [7:0]  bv_a;
    logic [31:0] rd_data_b;
    logic [1:0]  rd_busy_b;
    logic [7:0]  bv_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_R0(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(ra_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_a)
    );

    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(ra_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_b)
    );

    // One cycle of stimulus plus the outputs expected from both instances.
    // The data and hazard fields are combinational values seen before the edge.
    // The busy vectors are the values seen after the edge.
    typedef struct {
        logic        wae; logic [2:0] waa; logic [15:0] wad;
        logic        wbe; logic [2:0] wba; logic [15:0] wbd;
        logic        rse; logic [2:0] rsa;
        logic [2:0]  r0, r1, r2;
        logic [15:0] a0, a1, a2; logic [2:0] ab; logic [7:0] abv;
        logic [15:0] b0, b1;     logic [1:0] bb; logic [7:0] bbv;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    vec_t sb [$];
    vec_t cur;

    function automatic vec_t mk(
        input logic wae, input logic [2:0] waa, input logic [15:0] wad,
        input logic wbe, input logic [2:0] wba, input logic [15:0] wbd,
        input logic rse, input logic [2:0] rsa,
        input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
        input logic [2:0] ab, input logic [7:0] abv,
        input logic [15:0] b0, input logic [15:0] b1,
        input logic [1:0] bb, input logic [7:0] bbv);
        vec_t v;
        v.wae = wae; v.waa = waa; v.wad = wad;
        v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.rse = rse; v.rsa = rsa;
        v.r0 = r0; v.r1 = r1; v.r2 = r2;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.ab = ab; v.abv = abv;
        v.b0 = b0; v.b1 = b1; v.bb = bb; v.bbv = bbv;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wa_en = v.wae; wa_addr = v.waa; wa_data = v.wad;
        wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
        rsv_en = v.rse; rsv_addr = v.rsa;
        ra_a = {v.r2, v.r1, v.r0};
        ra_b = {v.r1, v.r0};
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        // Columns: A(en,addr,data) B(en,addr,data) RSV(en,addr) rd(p0,p1,p2)
        //          | dut_a data p0..p2, busy, busy_vec | dut_b data p0,p1, busy, busy_vec
        vecs[0]  = mk(1,5,16'h1234, 0,0,0,      0,0, 5,5,0, 16'h1234,16'h1234,16'h0000,3'b000,8'h00, 16'h0000,16'h0000,2'b00,8'h00);
        vecs[1]  = mk(0,0,0,        0,0,0,      0,0, 5,0,0, 16'h1234,16'h0000,16'h0000,3'b000,8'h00, 16'h1234,16'h0000,2'b00,8'h00);
        vecs[2]  = mk(1,2,16'hAAAA, 1,2,16'h5555, 0,0, 2,5,2, 16'hAAAA,16'h1234,16'hAAAA,3'b000,8'h00, 16'h0000,16'h1234,2'b00,8'h00);
        vecs[3]  = mk(1,1,16'h0011, 1,4,16'h0044, 0,0, 1,4,2, 16'h0011,16'h0044,16'hAAAA,3'b000,8'h00, 16'h0000,16'h0000,2'b00,8'h00);
        vecs[4]  = mk(0,0,0,        0,0,0,      0,0, 1,4,2, 16'h0011,16'h0044,16'hAAAA,3'b000,8'h00, 16'h0011,16'h0044,2'b00,8'h00);
        vecs[5]  = mk(0,0,0,        0,0,0,      1,6, 6,6,1, 16'h0000,16'h0000,16'h0011,3'b000,8'h40, 16'h0000,16'h0000,2'b00,8'h40);
        vecs[6]  = mk(0,0,0,        0,0,0,      0,0, 6,1,6, 16'h0000,16'h0011,16'h0000,3'b101,8'h40, 16'h0000,16'h0011,2'b01,8'h40);
        vecs[7]  = mk(0,0,0,        1,6,16'h0F0F, 0,0, 6,6,1, 16'h0F0F,16'h0F0F,16'h0011,3'b000,8'h00, 16'h0000,16'h0000,2'b11,8'h00);
        vecs[8]  = mk(0,0,0,        0,0,0,      0,0, 6,0,0, 16'h0F0F,16'h0000,16'h0000,3'b000,8'h00, 16'h0F0F,16'h0000,2'b00,8'h00);
        vecs[9]  = mk(1,6,16'hBEEF, 0,0,0,      1,6, 6,6,6, 16'hBEEF,16'hBEEF,16'hBEEF,3'b000,8'h40, 16'h0F0F,16'h0F0F,2'b00,8'h40);
        vecs[10] = mk(0,0,0,        0,0,0,      0,0, 6,6,6, 16'hBEEF,16'hBEEF,16'hBEEF,3'b111,8'h40, 16'hBEEF,16'hBEEF,2'b11,8'h40);
        vecs[11] = mk(1,0,16'hFFFF, 0,0,0,      1,0, 0,0,6, 16'hFFFF,16'hFFFF,16'hBEEF,3'b100,8'h41, 16'h0000,16'h0000,2'b00,8'h40);
        vecs[12] = mk(0,0,0,        0,0,0,      0,0, 0,0,0, 16'hFFFF,16'hFFFF,16'hFFFF,3'b111,8'h41, 16'h0000,16'h0000,2'b00,8'h40);
        vecs[13] = mk(1,7,16'h7777, 0,0,0,      0,0, 1,2,7, 16'h0011,16'hAAAA,16'h7777,3'b000,8'h41, 16'h0011,16'hAAAA,2'b00,8'h40);
        vecs[14] = mk(1,6,16'h6666, 1,0,16'h1111, 0,0, 0,6,7, 16'h1111,16'h6666,16'h7777,3'b000,8'h00, 16'h0000,16'hBEEF,2'b10,8'h00);
        vecs[15] = mk(0,0,0,        0,0,0,      0,0, 0,6,3, 16'h1111,16'h6666,16'h0000,3'b000,8'h00, 16'h0000,16'h6666,2'b00,8'h00);

        // Reset state: everything reads zero, and nothing is busy.
        rst_n = 1'b0;
        idle();
        ra_a = {3'd5, 3'd3, 3'd0};
        ra_b = {3'd3, 3'd0};
        #12;
        check("reset a.data", {16'h0, rd_data_a}, 64'h0);
        check("reset a.busy", {61'h0, rd_busy_a}, 64'h0);
        check("reset a.bv",   {56'h0, bv_a}, 64'h0);
        check("reset b.data", {32'h0, rd_data_b}, 64'h0);
        check("reset b.bv",   {56'h0, bv_b}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence with a scoreboard queue.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            #1;
            cur = sb.pop_front();
            check($sformatf("v%0d a.p0", i), {48'h0, rd_data_a[15:0]},  {48'h0, cur.a0});
            check($sformatf("v%0d a.p1", i), {48'h0, rd_data_a[31:16]}, {48'h0, cur.a1});
            check($sformatf("v%0d a.p2", i), {48'h0, rd_data_a[47:32]}, {48'h0, cur.a2});
            check($sformatf("v%0d a.busy", i), {61'h0, rd_busy_a}, {61'h0, cur.ab});
            check($sformatf("v%0d b.p0", i), {48'h0, rd_data_b[15:0]},  {48'h0, cur.b0});
            check($sformatf("v%0d b.p1", i), {48'h0, rd_data_b[31:16]}, {48'h0, cur.b1});
            check($sformatf("v%0d b.busy", i), {62'h0, rd_busy_b}, {62'h0, cur.bb});
            @(posedge clk);
            #1;
            check($sformatf("v%0d a.bv", i), {56'h0, bv_a}, {56'h0, cur.abv});
            check($sformatf("v%0d b.bv", i), {56'h0, bv_b}, {56'h0, cur.bbv});
        end

        // Mid-run reset: write 0xBEEF to r3 and reserve r5, then reset with a write pending.
        @(negedge clk);
        idle();
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'hBEEF;
        rsv_en = 1'b1; rsv_addr = 3'd5;
        ra_a = {3'd5, 3'd3, 3'd3};
        ra_b = {3'd5, 3'd3};
        @(posedge clk);
        #1;
        idle();
        #1;
        check("pre-rst a.r3", {48'h0, rd_data_a[15:0]}, 64'hBEEF);
        check("pre-rst a.bv", {56'h0, bv_a}, 64'h20);
        check("pre-rst a.busy p2", {63'h0, rd_busy_a[2]}, 64'h1);
        @(negedge clk);
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1234;
        rst_n = 1'b0;
        #1;
        check("in-rst a.data", {16'h0, rd_data_a}, 64'h0);
        check("in-rst a.busy", {61'h0, rd_busy_a}, 64'h0);
        check("in-rst a.bv",   {56'h0, bv_a}, 64'h0);
        check("in-rst b.bv",   {56'h0, bv_b}, 64'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        check("post-rst a.r3", {48'h0, rd_data_a[15:0]}, 64'h0);
        check("post-rst b.r3", {48'h0, rd_data_b[15:0]}, 64'h0);
        check("post-rst a.bv", {56'h0, bv_a}, 64'h0);
        check("post-rst a.busy", {61'h0, rd_busy_a}, 64'h0);

        // The first edge after release behaves normally.
        @(negedge clk);
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h00C3;
        rsv_en = 1'b1; rsv_addr = 3'd1;
        @(posedge clk);
        #1;
        idle();
        #1;
        check("rel a.r3", {48'h0, rd_data_a[15:0]}, 64'h00C3);
        check("rel b.r3", {48'h0, rd_data_b[15:0]}, 64'h00C3);
        check("rel a.bv", {56'h0, bv_a}, 64'h02);
        check("rel b.bv", {56'h0, bv_b}, 64'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
